// File: rtl/spi_reg_config.sv
// SPI mode-0 write-only configuration port: receives 16-bit frames from an off-chip controller
// and loads the five PWM configuration registers.
module spi_reg_config #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic [6:0] wr_addr
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_prev;
  logic                   ncs_prev;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  state_e      state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        frame_valid;

  // Synchronizers reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  assign frame_valid = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ncs_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= StShift;
          end
        end
        StShift: begin
          if (ncs_rise) begin
            state <= StCommit;
          end else if (sclk_rise && !ncs_s && (bit_cnt != 5'd16)) begin
            // Saturating at 16 keeps the captured frame intact when extra clocks arrive.
            shift_reg <= {shift_reg[14:0], copi_s};
            bit_cnt   <= bit_cnt + 5'd1;
          end
        end
        StCommit: begin
          if (frame_valid) begin
            wr_strobe <= 1'b1;
            wr_addr   <= shift_reg[14:8];
            case (shift_reg[14:8])
              7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
              7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
              7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
              7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
              7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
              default: ;
            endcase
          end
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_config.sv
// Directed bench for spi_reg_config: 10 MHz clk, 100 kHz SPI clock, hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_reg_config;

  localparam int HALF = 50;  // clk cycles per sclk half period
  localparam int GAP  = 5;   // minimum ncs-high time between frames

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;
  logic [6:0] wr_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int strobe_cyc = 0;
  int strobe_cnt = 0;
  int long_cnt = 0;
  int cnt_before;
  logic [6:0] last_addr = '0;
  logic prev_strobe = 1'b0;

  spi_reg_config #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (prev_strobe) long_cnt <= long_cnt + 1;
      strobe_cnt <= strobe_cnt + 1;
      last_addr  <= wr_addr;
      strobe_cyc <= cyc;
    end
    prev_strobe <= wr_strobe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, "_out_7_0"}, {24'h0, en_reg_out_7_0}, {24'h0, e0});
    check({tag, "_out_15_8"}, {24'h0, en_reg_out_15_8}, {24'h0, e1});
    check({tag, "_pwm_7_0"}, {24'h0, en_reg_pwm_7_0}, {24'h0, e2});
    check({tag, "_pwm_15_8"}, {24'h0, en_reg_pwm_15_8}, {24'h0, e3});
    check({tag, "_duty"}, {24'h0, pwm_duty_cycle}, {24'h0, e4});
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drops ncs and clocks out nbits of f MSB first; bits past the 16th are driven as 1.
  task automatic send_bits(input logic [15:0] f, input int nbits);
    ncs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b1;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap);
    wait_clk(HALF);
    ncs = 1'b1;
    rise_cyc = cyc;
    wait_clk(gap);
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits, input int gap);
    send_bits(f, nbits);
    end_frame(gap);
  endtask

  initial begin
    wait_clk(3);
    check("rst_strobe", {31'h0, wr_strobe}, 32'h0);
    rst_n = 1'b1;
    wait_clk(5);
    check_regs("init", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("init_strobe", {31'h0, wr_strobe}, 32'h0);
    check("init_addr", {25'h0, wr_addr}, 32'h0);

    // Single write to address 0x00
    send_frame(16'h80F0, 16, 10);
    check("t1_latency_ok", {31'h0, (strobe_cyc - rise_cyc >= 3) && (strobe_cyc - rise_cyc <= 5)},
          32'h1);
    check("t1_strobes", strobe_cnt, 1);
    check("t1_addr", {25'h0, last_addr}, 32'h0);
    check_regs("t1", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

    send_frame(16'h8480, 16, 10);
    send_frame(16'h82FF, 16, 10);
    check_regs("t2a", 8'hF0, 8'h00, 8'hFF, 8'h00, 8'h80);
    check("t2a_strobes", strobe_cnt, 3);

    // Ten back-to-back frames at minimum ncs-high time: addr i%5, data 0x10+i
    for (int i = 0; i < 10; i++) begin
      send_frame({1'b1, 7'(i % 5), 8'(8'h10 + i)}, 16, GAP);
    end
    wait_clk(10);
    check("t2b_strobes", strobe_cnt, 13);
    check("t2b_addr", {25'h0, last_addr}, 32'h4);
    check_regs("t2b", 8'h15, 8'h16, 8'h17, 8'h18, 8'h19);

    // Read frame and out-of-range write
    send_frame(16'h0055, 16, 10);
    send_frame(16'hB0AA, 16, 10);
    check("t3_strobes", strobe_cnt, 13);
    check_regs("t3", 8'h15, 8'h16, 8'h17, 8'h18, 8'h19);

    // Short frame discarded, long frame keeps its first 16 bits
    send_frame(16'h8177, 15, 10);
    check("t4a_strobes", strobe_cnt, 13);
    send_frame(16'h813C, 17, 10);
    check("t4b_strobes", strobe_cnt, 14);
    check("t4b_addr", {25'h0, last_addr}, 32'h1);
    check_regs("t4", 8'h15, 8'h3C, 8'h17, 8'h18, 8'h19);

    // Reset mid-frame
    send_bits(16'h8499, 8);
    rst_n = 1'b0;
    wait_clk(2);
    check_regs("t5_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("t5_rst_addr", {25'h0, wr_addr}, 32'h0);
    ncs = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(20);
    check("t5_no_commit", strobe_cnt, 14);
    check_regs("t5_post", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(16'h8410, 16, 10);
    check("t5_strobes", strobe_cnt, 15);
    check_regs("t5", 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);

    // sclk activity with ncs high
    cnt_before = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      copi = ~copi;
      sclk = 1'b1;
      wait_clk(10);
      sclk = 1'b0;
      wait_clk(10);
    end
    wait_clk(10);
    check("t6_strobes", strobe_cnt, cnt_before);
    check_regs("t6", 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);
    check("t6_after_write", {24'h0, pwm_duty_cycle}, 32'h10);

    send_frame(16'h8355, 16, 10);
    check("t7_strobes", strobe_cnt, cnt_before + 1);
    check_regs("t7", 8'h00, 8'h00, 8'h00, 8'h55, 8'h10);
    check("strobe_width", long_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
